// File: rtl/act_loader.sv
// rtl/act_loader.sv - packs streamed activations into memory words and writes them to sequential addresses
module act_loader #(
   parameter int GROUP_SIZE       = 2,
   parameter int ACTIVATION_WIDTH = 8,
   parameter int LOG_MAX_ADDRESS  = 16,
   parameter int LOG_MAX_VALUES   = 20
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic                                 i_configure,
   input  logic [LOG_MAX_ADDRESS-1:0]           i_base_address,
   input  logic [LOG_MAX_VALUES-1:0]            i_num_values,
   input  logic                                 i_valid_in,
   input  logic [ACTIVATION_WIDTH-1:0]          i_data_in,
   output logic                                 o_avail_out,
   output logic [GROUP_SIZE*ACTIVATION_WIDTH-1:0] o_data_write,
   output logic [LOG_MAX_ADDRESS-1:0]           o_addr_write,
   output logic                                 o_write,
   output logic                                 o_busy,
   output logic                                 o_done
);

   localparam int LANE_W = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
   localparam int WORD_W = GROUP_SIZE * ACTIVATION_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_state_next;
   logic [LOG_MAX_ADDRESS-1:0] r_addr_cnt;
   logic [LOG_MAX_VALUES-1:0]  r_remaining;
   logic [LANE_W-1:0]          r_lane;
   logic [WORD_W-1:0]          r_pack;
   logic [WORD_W-1:0]          r_data_write;
   logic [LOG_MAX_ADDRESS-1:0] r_addr_write;
   logic                       r_write;

   logic                       w_accept;
   logic                       w_last;
   logic                       w_group_full;
   logic                       w_flush;
   logic [WORD_W-1:0]          w_pack_next;

   // avail is decoded from state alone so the producer never sees a combinational path from valid
   assign o_avail_out  = (r_state == S_LOAD);
   assign o_busy       = (r_state != S_IDLE);
   assign o_done       = (r_state == S_DONE);
   assign o_data_write = r_data_write;
   assign o_addr_write = r_addr_write;
   assign o_write      = r_write;

   assign w_accept     = i_valid_in && o_avail_out;
   assign w_last       = w_accept && (r_remaining == LOG_MAX_VALUES'(1));
   assign w_group_full = w_accept && (r_lane == LANE_W'(GROUP_SIZE - 1));
   assign w_flush      = w_last || w_group_full;

   // Insert the incoming activation into its lane of the partially built word
   always_comb begin
      w_pack_next = r_pack;
      for (int i = 0; i < GROUP_SIZE; i++) begin
         if (r_lane == LANE_W'(i)) begin
            w_pack_next[i*ACTIVATION_WIDTH +: ACTIVATION_WIDTH] = i_data_in;
         end
      end
   end

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode; configure only matters in IDLE, an empty load goes straight to DONE
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_configure) begin
               w_state_next = (i_num_values != '0) ? S_LOAD : S_DONE;
            end
         end
         S_LOAD: begin
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Load counters and pack register; the pack register restarts empty for each group
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_addr_cnt  <= '0;
         r_remaining <= '0;
         r_lane      <= '0;
         r_pack      <= '0;
      end else begin
         if (r_state == S_IDLE && i_configure) begin
            r_addr_cnt  <= i_base_address;
            r_remaining <= i_num_values;
            r_lane      <= '0;
            r_pack      <= '0;
         end else if (w_accept) begin
            r_remaining <= r_remaining - LOG_MAX_VALUES'(1);
            if (w_flush) begin
               r_lane     <= '0;
               r_pack     <= '0;
               r_addr_cnt <= r_addr_cnt + LOG_MAX_ADDRESS'(1);
            end else begin
               r_lane <= r_lane + LANE_W'(1);
               r_pack <= w_pack_next;
            end
         end
      end
   end

   // Registered memory write port; data and address hold between strobes
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_write      <= 1'b0;
         r_data_write <= '0;
         r_addr_write <= '0;
      end else begin
         r_write <= w_flush;
         if (w_flush) begin
            r_data_write <= w_pack_next;
            r_addr_write <= r_addr_cnt;
         end
      end
   end

endmodule

// File: tb/tb_act_loader.sv
// tb/tb_act_loader.sv - randomized self-checking bench for act_loader
module tb_act_loader;

   localparam int G  = 2;
   localparam int AW = 8;
   localparam int LA = 16;
   localparam int LV = 20;

   logic            clk = 1'b0;
   logic            rst;
   logic            configure;
   logic [LA-1:0]   base_address;
   logic [LV-1:0]   num_values;
   logic            valid_in;
   logic [AW-1:0]   data_in;
   logic            avail_out;
   logic [G*AW-1:0] data_write;
   logic [LA-1:0]   addr_write;
   logic            write;
   logic            busy;
   logic            done;

   int n_vec = 0;
   int n_err = 0;

   logic [AW-1:0]   vals     [0:255];
   logic [G*AW-1:0] exp_word [0:255];
   logic [LA-1:0]   exp_addr [0:255];

   act_loader #(
      .GROUP_SIZE(G), .ACTIVATION_WIDTH(AW), .LOG_MAX_ADDRESS(LA), .LOG_MAX_VALUES(LV)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_configure(configure), .i_base_address(base_address),
      .i_num_values(num_values), .i_valid_in(valid_in), .i_data_in(data_in),
      .o_avail_out(avail_out), .o_data_write(data_write), .o_addr_write(addr_write),
      .o_write(write), .o_busy(busy), .o_done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: word g holds values g*G .. g*G+G-1 (lane 0 in LSBs, missing lanes zero) at base+g
   task automatic build_expect(input logic [LA-1:0] base, input int n);
      logic [G*AW-1:0] word;
      for (int g = 0; g * G < n; g++) begin
         word = '0;
         for (int l = 0; l < G; l++) begin
            if (g * G + l < n) word[l*AW +: AW] = vals[g*G + l];
         end
         exp_word[g] = word;
         exp_addr[g] = base + LA'(g);
      end
   endtask

   // mode: 0 valid every cycle, 1 random valid, 2 valid pattern 1,0,0,1,0,0,...
   task automatic run_load(input logic [LA-1:0] base, input int n, input int mode, input bit mid_cfg);
      int idx = 0;
      int wr  = 0;
      int cyc = 0;
      bit pend = 1'b0;
      bit acc;
      build_expect(base, n);
      @(negedge clk);
      configure = 1'b1; base_address = base; num_values = LV'(n);
      @(negedge clk);
      configure = 1'b0; base_address = LA'($urandom); num_values = LV'($urandom);
      if (n == 0) begin
         check("zero_done", done, 1);
         check("zero_write", write, 0);
         check("zero_avail", avail_out, 0);
         @(negedge clk);
         check("zero_done_clr", done, 0);
         check("zero_busy", busy, 0);
         check("zero_avail2", avail_out, 0);
         check("zero_write2", write, 0);
         return;
      end
      while (idx < n && cyc < 4000) begin
         check("avail", avail_out, 1);
         check("busy", busy, 1);
         check("done_early", done, 0);
         if (pend) begin
            check("write", write, 1);
            check("data", data_write, exp_word[wr]);
            check("addr", addr_write, exp_addr[wr]);
            wr++;
         end else begin
            check("no_write", write, 0);
         end
         pend = 1'b0;
         if (mid_cfg && cyc == 1) begin
            configure = 1'b1; base_address = ~base; num_values = LV'(n + 5);
         end else begin
            configure = 1'b0;
         end
         case (mode)
            0:       acc = 1'b1;
            1:       acc = 1'($urandom_range(0, 1));
            default: acc = (cyc % 3 == 0);
         endcase
         valid_in = acc;
         data_in  = acc ? vals[idx] : AW'($urandom);
         if (acc) begin
            pend = ((idx % G) == G - 1) || (idx == n - 1);
            idx++;
         end
         cyc++;
         @(negedge clk);
      end
      valid_in = 1'b0; configure = 1'b0;
      if (idx < n) check("timeout", idx, n);
      check("final_write", write, 1);
      check("final_data", data_write, exp_word[wr]);
      check("final_addr", addr_write, exp_addr[wr]);
      wr++;
      check("final_done", done, 1);
      check("final_avail", avail_out, 0);
      check("final_busy", busy, 1);
      check("write_count", wr, (n + G - 1) / G);
      @(negedge clk);
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      check("post_write", write, 0);
      check("post_avail", avail_out, 0);
   endtask

   task automatic reset_mid_load();
      @(negedge clk);
      configure = 1'b1; base_address = 16'h0040; num_values = LV'(4);
      @(negedge clk);
      configure = 1'b0; valid_in = 1'b1; data_in = 8'h5A;
      @(negedge clk);
      valid_in = 1'b0;
      check("rst_pre_nowrite", write, 0);
      rst = 1'b1;
      #1;
      check("rst_avail", avail_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_write", write, 0);
      check("rst_data", data_write, 0);
      check("rst_addr", addr_write, 0);
      @(negedge clk);
      check("rst_hold_write", write, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_after_write", write, 0);
      check("rst_after_busy", busy, 0);
   endtask

   initial begin
      rst = 1'b1; configure = 1'b0; base_address = '0; num_values = '0;
      valid_in = 1'b0; data_in = '0;
      @(negedge clk);
      @(negedge clk);
      check("reset_avail", avail_out, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_write", write, 0);
      check("reset_data", data_write, 0);
      check("reset_addr", addr_write, 0);
      rst = 1'b0;

      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
      run_load(16'h0010, 4, 0, 1'b0);

      vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3;
      run_load(16'h0100, 3, 0, 1'b0);

      run_load(16'h0300, 0, 0, 1'b0);

      for (int i = 0; i < 4; i++) vals[i] = AW'($urandom);
      run_load(16'hFFFF, 4, 0, 1'b0);

      for (int i = 0; i < 2; i++) vals[i] = AW'($urandom);
      run_load(16'h0500, 2, 2, 1'b1);

      reset_mid_load();
      for (int i = 0; i < 5; i++) vals[i] = AW'($urandom);
      run_load(16'h0200, 5, 0, 1'b0);

      for (int t = 0; t < 8; t++) begin
         int n;
         n = $urandom_range(1, 40);
         for (int i = 0; i < n; i++) vals[i] = AW'($urandom);
         run_load(LA'($urandom), n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/act_loader.md
Name: act_loader

Overview:
- Host-side fill stage that sits upstream of the activation memory (MEM) of the accelerator.
- Accepts a stream of single activations (one per beat) on a valid/avail handshake and packs GROUP_SIZE of them into one memory word.
- Writes each packed word to consecutive addresses starting at a configured base address.
- Signals completion so the controller can then configure the READ stage.

Parameters:
GROUP_SIZE, 2, activations packed per memory word
ACTIVATION_WIDTH, 8, bits per activation
LOG_MAX_ADDRESS, 16, memory address width
LOG_MAX_VALUES, 20, width of the activation count

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
configure  in  1  start pulse; samples base_address and num_values
base_address  in  LOG_MAX_ADDRESS  first write address
num_values  in  LOG_MAX_VALUES  activations to load
valid_in  in  1  data_in holds a valid activation
data_in  in  ACTIVATION_WIDTH  activation value
avail_out  out  1  loader can accept an activation this cycle
data_write  out  GROUP_SIZE*ACTIVATION_WIDTH  packed word to MEM
addr_write  out  LOG_MAX_ADDRESS  write address to MEM
write  out  1  write strobe to MEM
busy  out  1  load in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - avail_out, write, busy and done are 0; data_write and addr_write are 0.
  - Lane counter, value counter and pack register are cleared.
  - Any partial group is discarded. Reset mid-load aborts with no further writes.
- FSM states IDLE, LOAD, DONE:
  - IDLE: configure=1 latches base_address into addr_cnt and num_values into remaining; lane=0; pack register cleared. Next state is LOAD if num_values>0, else DONE.
  - LOAD: avail_out=1 (decoded from state only, never from valid_in). An activation is accepted when valid_in && avail_out.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in LOAD and DONE.
- configure is ignored outside IDLE.
- Packing:
  - The k-th accepted value goes to lane k mod GROUP_SIZE, occupying bits [lane*ACTIVATION_WIDTH +: ACTIVATION_WIDTH]. Lane 0 is at the LSBs.
- Write generation (registered):
  - Triggered by an accept at cycle t that either fills lane GROUP_SIZE-1 or is the last value (remaining==1).
  - At t+1: write=1, data_write = packed word, addr_write = addr_cnt.
  - Lanes not filled in a final partial group are written as 0.
  - After each write, addr_cnt increments, wrapping modulo 2^LOG_MAX_ADDRESS with no error.
  - write=0 in all other cycles. data_write and addr_write hold their last values.
- Completion:
  - The accept of the last value at t moves the FSM to DONE at t+1.
  - avail_out=0 from t+1.
  - The final write and the done pulse coincide in cycle t+1.
- num_values=0: configure at t gives done=1 at t+1 with no write and avail_out never asserted.
- valid_in gaps: no accept occurs and the lane and counters hold. Arbitrary bubbles are allowed.
- Throughput: one activation per cycle; at most one write every GROUP_SIZE accepts.
- Counters:
  - remaining is LOG_MAX_VALUES bits and decrements per accept.
  - lane is clog2(GROUP_SIZE) bits, minimum 1.

Test Plan:
- GROUP_SIZE=2, base=0x0010, num_values=4, data 0x11,0x22,0x33,0x44 back-to-back -> writes {0x2211}@0x0010, {0x4433}@0x0011. done is high in the same cycle as the second write, then busy=0.
- num_values=3, data 0xA1,0xB2,0xC3 -> writes 0xB2A1@base, 0x00C3@base+1. avail_out is 0 the cycle after the third accept.
- num_values=0, configure pulse -> done=1 next cycle, no write, avail_out stays 0.
- base=0xFFFF, num_values=4 -> writes at 0xFFFF then 0x0000 (wrap).
- valid_in toggled 1,0,0,1 during load -> only the 2 valid values are packed, into one word, and no spurious write occurs. A configure pulse mid-LOAD is ignored: base and count are unchanged.
- Assert rst after 1 of 4 values accepted -> all outputs 0 immediately, no write of the partial group. A new configure then loads correctly from its base.
